// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, frame width and the bit-period helper.
// Also intended for the transmit side of the link.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Clock cycles per serial bit (integer division).
    function automatic int cpb(input int br, input int clkf);
        return clkf / br;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Serial line plus byte-side valid/ready holding-register signals of the UART receiver.
interface uart_receiver_if;
    import uart_pkg::*;

    logic                 rx;
    logic                 ready;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx, ready,
        input  data, valid, frame_err, overrun
    );

    modport slave (
        input  rx, ready,
        output data, valid, frame_err, overrun
    );

endinterface

// File: rtl/rx_synchronizer.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset level.
module rx_synchronizer #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling derived from clk, one-entry valid/ready holding register,
// frame-error and overrun pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BR   = 115200,
    parameter int CLKF = 50000000
) (
    input  logic           clk,
    input  logic           reset,
    uart_receiver_if.slave bus
);

    localparam int CPB  = cpb(BR, CLKF);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int BW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    generate
        if (CPB < 4) begin : g_cpb_check
            $error("uart_receiver: CLKF/BR must be at least 4");
        end
    endgenerate

    logic                 w_rx_s;
    rx_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    rx_synchronizer #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.rx),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            // NOTE: a consumer handshake clears valid here, but a delivery later in this
            // block re-sets it; the last non-blocking assignment in the cycle wins.
            if (r_valid && bus.ready) r_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_cnt   <= '0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_bit_idx <= '0;
                            r_state   <= ST_DATA;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt   <= '0;
                        r_shreg <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
                        if (r_bit_idx == LAST_BIT) r_state <= ST_STOP;
                        else r_bit_idx <= r_bit_idx + BW'(1);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= ST_IDLE;
                            if (!r_valid || bus.ready) begin
                                r_data  <= r_shreg;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_BREAK: begin
                    // A line held low must go idle before another start bit is honoured.
                    if (w_rx_s) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Receives 8N1 asynchronous serial frames on a single line and presents each byte through a one-entry valid/ready holding register. It is the receive end of the UART link whose bit timing is set by `BaudRateGenerator`. It takes the same `BR`/`CLKF` parameters and derives its own mid-bit sampling from `clk`, so it needs no shared baud clock. The peer transmitter may run from an unrelated clock.

## Interface
- `BR`, 115200, baud rate in bits/s.
- `CLKF`, 50000000, `clk` frequency in Hz. `CPB = CLKF/BR` (integer division) must be at least 4; elaboration fails otherwise.
- `clk`  input  1  system clock. This is the only clock.
- `reset`  input  1  synchronous, active-high.
- `rx`  input  1  serial line. Idle is high. It is asynchronous to `clk`.
- `ready`  input  1  the consumer accepts `data` this cycle.
- `data`  output  8  received byte. Valid while `valid` = 1.
- `valid`  output  1  the holding register is full.
- `frame_err`  output  1  one-cycle pulse: the stop bit was sampled low and the byte was discarded.
- `overrun`  output  1  one-cycle pulse: a byte completed while the holding register was full, and the new byte was dropped.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1.
- Derived constants: `CPB = CLKF/BR` and `HALF = CPB/2`. The counter width is `$clog2(CPB)`.
- The FSM has five states: IDLE, START, DATA, STOP, BREAK.
- IDLE: when `rx_s` == 0, clear the counter and go to START.
- START: count to `HALF-1`, then sample `rx_s`.
  - If the sample is 0, go to DATA with counter = 0 and bit index = 0.
  - If the sample is 1 (glitch), go to IDLE.
- DATA: count to `CPB-1`, then sample `rx_s`.
  - Data is LSB first. Shift right into `shreg[7]`.
  - After the 8th sample, go to STOP.
- STOP: count to `CPB-1`, then sample `rx_s`.
  - If the sample is 1, deliver the byte and go to IDLE.
  - If the sample is 0, pulse `frame_err` and go to BREAK.
- BREAK: wait for `rx_s` == 1, then go to IDLE. This prevents a held-low line from re-triggering.
- Delivery rules:
  - If `valid` == 0, or `valid` and `ready` are both 1 in the delivery cycle: `data <= shreg`, `valid <= 1`.
  - If `valid` == 1 and `ready` == 0: pulse `overrun` and keep the old `data`.
- `valid` clears on a cycle where `valid` && `ready` and no delivery occurs.
- `data` is stable while `valid` == 1 until the handshake completes.

## Timing
- Let D be the first cycle in which the FSM sees `rx_s` == 0 in IDLE. D is 2 cycles after `rx` falls at a clock edge.
- Sample k (0 = start, 1–8 = data, 9 = stop) is taken at cycle `D + HALF + k*CPB`.
- `valid` rises, or `overrun`/`frame_err` pulses, in cycle `D + HALF + 9*CPB + 1`.
- After a good stop bit, a new start bit is detected as soon as `rx_s` is low in IDLE, about half a bit before the nominal stop-bit end.
- Reset values:
  - `data` = 0, `valid` = 0, `frame_err` = 0, `overrun` = 0.
  - FSM = IDLE, counters = 0, `shreg` = 0, synchronizer = 1.
- Reset mid-frame aborts the frame silently with no error pulse. It also clears a pending `valid`.
- `ready` has no effect while `valid` == 0.

## Structure
- `uart_pkg` holds the FSM state encoding, a `cpb(BR, CLKF)` constant function, and `DATA_BITS = 8`. The future `uart_transmitter` shares it.
- Sub-module `rx_synchronizer`: 2-flop synchronizer with a reset value parameter. It is reusable for other async inputs.
- The FSM, counter, shift register and holding register live in `uart_receiver`.

## Test plan
All scenarios use `BR` = 10 and `CLKF` = 160, so `CPB` = 16 and `HALF` = 8. The bench drives `rx` at bit rate from the same `clk`.
- Reset: hold `reset` 5 cycles with `rx` = 0, then release with `rx` = 1 for 200 cycles. Required: all outputs 0 throughout, and `valid` never asserts.
- Single byte: send 0xA5 with `ready` = 0. Required: `valid` rises exactly at D+153 with `data` = 8'hA5 and stays held. Assert `ready` for 1 cycle → `valid` = 0 next cycle.
- Glitch: pulse `rx` low for 4 cycles. Required: no `valid` and no `frame_err`. Then send 0x3C → `data` = 8'h3C.
- Framing/break: send 0x55 with the stop bit low and `rx` held low 40 more cycles. Required: exactly one `frame_err` pulse at D+153 and no `valid`. After `rx` returns high, send 0x0F → `data` = 8'h0F, `frame_err` stays 0.
- Overrun: send 0x11 then 0x22 back-to-back with `ready` = 0. Required: `data` = 8'h11 with `valid` = 1, and one `overrun` pulse at the second completion. `data` is still 8'h11 afterwards.
- Reset mid-frame: assert `reset` 1 cycle during data bit 4 of 0x99. Required: no `valid` and no error pulses for that frame. The next frame 0xFF yields `data` = 8'hFF.
